// File: rtl/dth11_pkg.sv
// Shared types and frame layout for the DHT11 read sequencer.
package dth11_pkg;

  localparam int unsigned DTH_FRAME_BITS = 40;

  // Byte positions inside the 40-bit frame, MSB first on the wire.
  localparam int unsigned HUM_INT_LSB  = 32;
  localparam int unsigned HUM_DEC_LSB  = 24;
  localparam int unsigned TEMP_INT_LSB = 16;
  localparam int unsigned TEMP_DEC_LSB = 8;
  localparam int unsigned CHKSUM_LSB   = 0;

  typedef enum logic [3:0] {
    StIdle     = 4'd0,
    StStartLow = 4'd1,
    StWaitResp = 4'd2,
    StRespLow  = 4'd3,
    StRespHigh = 4'd4,
    StBitLow   = 4'd5,
    StBitHigh  = 4'd6,
    StCheck    = 4'd7,
    StDone     = 4'd8,
    StError    = 4'd9
  } dth_state_e;

  // Modulo-256 sum of the four data bytes.
  function automatic logic [7:0] dth_sum(input logic [DTH_FRAME_BITS-1:0] frame);
    dth_sum = frame[HUM_INT_LSB +: 8] + frame[HUM_DEC_LSB +: 8] +
              frame[TEMP_INT_LSB +: 8] + frame[TEMP_DEC_LSB +: 8];
  endfunction

endpackage

// File: rtl/dth11_us_tick.sv
// Free-running divider: one-cycle pulse every CLKS_PER_US clocks.
module dth11_us_tick #(
  parameter int unsigned CLKS_PER_US = 50
) (
  input  logic i_Clock,
  input  logic i_Reset,
  output logic o_Us_Tick
);

  localparam int unsigned CntW = (CLKS_PER_US > 1) ? $clog2(CLKS_PER_US) : 1;
  localparam logic [CntW-1:0] DivMax = CntW'(CLKS_PER_US - 1);

  logic [CntW-1:0] div_q, div_d;

  always_comb begin
    div_d = (div_q == DivMax) ? '0 : div_q + 1'b1;
  end

  always_ff @(posedge i_Clock) begin
    if (i_Reset) begin
      div_q <= '0;
    end else begin
      div_q <= div_d;
    end
  end

  assign o_Us_Tick = (div_q == DivMax);

endmodule

// File: rtl/dth11_controller.sv
// DHT11 single-wire read sequencer: start pulse, preamble, 40 timed bits, checksum.
// Define DTH11_CHECKSUM_EN to reject frames whose checksum byte does not match.
module dth11_controller
  import dth11_pkg::*;
#(
  parameter int unsigned CLK_FREQ_HZ   = 50_000_000,
  parameter int unsigned START_LOW_US  = 18000,
  parameter int unsigned TIMEOUT_US    = 200,
  parameter int unsigned BIT_THRESH_US = 40
) (
  input  logic                      i_Clock,
  input  logic                      i_Reset,
  input  logic                      i_Dth_Start,
  input  logic                      i_Dth_Line,
  output logic                      o_Dth_Drive_Low,
  output logic [DTH_FRAME_BITS-1:0] o_Dth_Data,
  output logic                      o_Dth_Done,
  output logic                      o_Dth_Error,
  output logic                      o_Busy
);

  localparam int unsigned ClksPerUs = CLK_FREQ_HZ / 1_000_000;
  localparam logic [15:0] StartLowM1 = 16'(START_LOW_US - 1);
  localparam logic [15:0] Timeout    = 16'(TIMEOUT_US);
  localparam logic [15:0] Thresh     = 16'(BIT_THRESH_US);
  localparam logic [5:0]  LastBit    = 6'(DTH_FRAME_BITS - 1);

  dth_state_e                state_q, state_d;
  logic [15:0]               cnt_q, cnt_d;
  logic [5:0]                idx_q, idx_d;
  logic [DTH_FRAME_BITS-1:0] shift_q, shift_d;
  logic [DTH_FRAME_BITS-1:0] data_q, data_d;
  logic                      err_q, err_d;
  logic                      line_meta_q, line_sync_q;
  logic                      us_tick;
  logic                      timed_out;

  dth11_us_tick #(
    .CLKS_PER_US(ClksPerUs)
  ) u_us_tick (
    .i_Clock  (i_Clock),
    .i_Reset  (i_Reset),
    .o_Us_Tick(us_tick)
  );

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    shift_d = shift_q;
    data_d  = data_q;
    err_d   = err_q;
    // The edge-detect cycle is spent before the counter clears, so the phase
    // length seen on the wire is cnt_q + 1 ticks.
    timed_out = (cnt_q >= Timeout);

    unique case (state_q)
      StIdle: begin
        if (i_Dth_Start) begin
          err_d   = 1'b0;
          state_d = StStartLow;
        end
      end
      StStartLow: begin
        if (us_tick && (cnt_q >= StartLowM1)) state_d = StWaitResp;
      end
      StWaitResp: begin
        if (timed_out)         state_d = StError;
        else if (!line_sync_q) state_d = StRespLow;
      end
      StRespLow: begin
        if (timed_out)        state_d = StError;
        else if (line_sync_q) state_d = StRespHigh;
      end
      StRespHigh: begin
        if (timed_out) begin
          state_d = StError;
        end else if (!line_sync_q) begin
          idx_d   = '0;
          shift_d = '0;
          state_d = StBitLow;
        end
      end
      StBitLow: begin
        if (timed_out)        state_d = StError;
        else if (line_sync_q) state_d = StBitHigh;
      end
      StBitHigh: begin
        if (timed_out) begin
          state_d = StError;
        end else if (!line_sync_q) begin
          shift_d = {shift_q[DTH_FRAME_BITS-2:0], (cnt_q >= Thresh)};
          idx_d   = idx_q + 6'd1;
          state_d = (idx_q == LastBit) ? StCheck : StBitLow;
        end
      end
      StCheck: begin
`ifdef DTH11_CHECKSUM_EN
        if (dth_sum(shift_q) == shift_q[CHKSUM_LSB +: 8]) begin
          data_d  = shift_q;
          state_d = StDone;
        end else begin
          state_d = StError;
        end
`else
        data_d  = shift_q;
        state_d = StDone;
`endif
      end
      StDone:  state_d = StIdle;
      StError: state_d = StIdle;
      default: state_d = StIdle;
    endcase

    if (state_d == StError) err_d = 1'b1;

    if (state_d != state_q)            cnt_d = '0;
    else if (us_tick && (cnt_q != '1)) cnt_d = cnt_q + 16'd1;
    else                               cnt_d = cnt_q;
  end

  always_ff @(posedge i_Clock) begin
    if (i_Reset) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      idx_q       <= '0;
      shift_q     <= '0;
      data_q      <= '0;
      err_q       <= 1'b0;
      line_meta_q <= 1'b1;
      line_sync_q <= 1'b1;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      idx_q       <= idx_d;
      shift_q     <= shift_d;
      data_q      <= data_d;
      err_q       <= err_d;
      line_meta_q <= i_Dth_Line;
      line_sync_q <= line_meta_q;
    end
  end

  assign o_Dth_Drive_Low = (state_q == StStartLow);
  assign o_Dth_Done      = (state_q == StDone) || (state_q == StError);
  assign o_Busy          = (state_q != StIdle);
  assign o_Dth_Error     = err_q;
  assign o_Dth_Data      = data_q;

endmodule

// File: tb/tb_dth11_controller.sv
// Self-checking bench: sensor BFM on the line plus a rule-level reference model.
module tb_dth11_controller;

  localparam int TimeoutUs  = 200;
  localparam int ThreshUs   = 40;
  localparam int StartLowUs = 100;

  logic        clk = 1'b0;
  logic        rst, start, line;
  logic        drv, done, err, busy;
  logic [39:0] data;

  dth11_controller #(
    .CLK_FREQ_HZ  (1_000_000),
    .START_LOW_US (StartLowUs),
    .TIMEOUT_US   (TimeoutUs),
    .BIT_THRESH_US(ThreshUs)
  ) dut (
    .i_Clock        (clk),
    .i_Reset        (rst),
    .i_Dth_Start    (start),
    .i_Dth_Line     (line),
    .o_Dth_Drive_Low(drv),
    .o_Dth_Data     (data),
    .o_Dth_Done     (done),
    .o_Dth_Error    (err),
    .o_Busy         (busy)
  );

  always #5 clk = ~clk;

  int          errors = 0;
  int          checks = 0;
  int          done_cnt = 0;
  time         done_time;
  logic        done_err;
  logic [39:0] done_data;

  always @(negedge clk) begin
    if (done) begin
      done_cnt++;
      done_time = $time;
      done_err  = err;
      done_data = data;
    end
  end

  // Sensor timing for the next transaction, in microseconds (= cycles here).
  int          wait_us, resp_lo, resp_hi;
  int          bit_lo[40];
  int          bit_hi[40];
  time         rise_time[40];
  int          drv_glitch;
  logic [39:0] exp_data;

  // Reference: each bit is 1 when its high phase exceeds the threshold.
  function automatic logic [39:0] model_frame();
    logic [39:0] f;
    for (int i = 0; i < 40; i++) f[39-i] = (bit_hi[i] > ThreshUs);
    return f;
  endfunction

  function automatic bit model_error(input bit responds);
    if (!responds || wait_us > TimeoutUs || resp_lo > TimeoutUs || resp_hi > TimeoutUs)
      return 1'b1;
    for (int i = 0; i < 40; i++)
      if (bit_lo[i] > TimeoutUs || bit_hi[i] > TimeoutUs) return 1'b1;
`ifdef DTH11_CHECKSUM_EN
    begin : chk
      logic [39:0] f;
      int          s;
      f = model_frame();
      s = (int'(f[39:32]) + int'(f[31:24]) + int'(f[23:16]) + int'(f[15:8])) % 256;
      if (s != int'(f[7:0])) return 1'b1;
    end
`endif
    return 1'b0;
  endfunction

  function automatic logic [39:0] make_frame(input bit good);
    logic [7:0] b3, b2, b1, b0, c;
    b3 = 8'($urandom);
    b2 = 8'($urandom);
    b1 = 8'($urandom);
    b0 = 8'($urandom);
    c  = b3 + b2 + b1 + b0;
    if (!good) c = c + 8'd1 + 8'($urandom_range(253, 0));
    return {b3, b2, b1, b0, c};
  endfunction

  task automatic set_timing(input logic [39:0] f, input int h0, input int h1);
    wait_us = 30;
    resp_lo = 80;
    resp_hi = 80;
    for (int i = 0; i < 40; i++) begin
      bit_lo[i] = 50;
      bit_hi[i] = f[39-i] ? h1 : h0;
    end
  endtask

  task automatic set_random_timing(input logic [39:0] f);
    wait_us = $urandom_range(40, 20);
    resp_lo = $urandom_range(90, 70);
    resp_hi = $urandom_range(90, 70);
    for (int i = 0; i < 40; i++) begin
      bit_lo[i] = $urandom_range(60, 35);
      bit_hi[i] = f[39-i] ? $urandom_range(75, 41) : $urandom_range(40, 18);
    end
  endtask

  task automatic wait_n(input int n);
    repeat (n) begin
      @(negedge clk);
      if (drv) drv_glitch++;
    end
  endtask

  task automatic pulse_start();
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
  endtask

  task automatic wait_release(output int low_len);
    int guard;
    guard   = 0;
    low_len = 0;
    while (!drv && guard < 10) begin
      @(negedge clk);
      guard++;
    end
    while (drv && low_len < 20000) begin
      @(negedge clk);
      low_len++;
    end
  endtask

  // Plays preamble and bits; stops right after the rising edge of stop_bit.
  task automatic sensor_play(input int stop_bit);
    wait_n(wait_us);
    line = 1'b0;
    wait_n(resp_lo);
    line = 1'b1;
    wait_n(resp_hi);
    for (int i = 0; i < 40; i++) begin
      line = 1'b0;
      wait_n(bit_lo[i]);
      line = 1'b1;
      rise_time[i] = $time;
      if (i == stop_bit) return;
      wait_n(bit_hi[i]);
    end
    line = 1'b0;
  endtask

  task automatic finish_txn();
    for (int k = 0; k < 60; k++) begin
      @(negedge clk);
      if (done) start = 1'b0;
    end
    start = 1'b0;
    line  = 1'b1;
    repeat (5) @(negedge clk);
  endtask

  task automatic run_txn(output int low_len);
    pulse_start();
    wait_release(low_len);
    sensor_play(40);
    finish_txn();
  endtask

  task automatic test_reset();
    rst   = 1'b1;
    start = 1'b0;
    line  = 1'b1;
    repeat (3) @(negedge clk);
    checks += 5;
    if (drv !== 1'b0) begin errors++; $display("FAIL reset_drive: got %b want 0", drv); end
    if (data !== 40'h0) begin errors++; $display("FAIL reset_data: got %h want 0", data); end
    if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b want 0", done); end
    if (err !== 1'b0) begin errors++; $display("FAIL reset_error: got %b want 0", err); end
    if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
    rst = 1'b0;
    exp_data = '0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_nominal(input string name);
    int n0, len;
    bit exp_e;
    set_timing(40'h28_001A_0042, 27, 70);
    n0 = done_cnt;
    run_txn(len);
    exp_e = model_error(1'b1);
    if (!exp_e) exp_data = model_frame();
    checks += 5;
    if (len != StartLowUs) begin errors++; $display("FAIL %s_start_low: got %0d want %0d", name, len, StartLowUs); end
    if (done_cnt - n0 != 1) begin errors++; $display("FAIL %s_done_count: got %0d want 1", name, done_cnt - n0); end
    if (done_err !== exp_e) begin errors++; $display("FAIL %s_error: got %b want %b", name, done_err, exp_e); end
    if (done_data !== exp_data) begin errors++; $display("FAIL %s_data: got %h want %h", name, done_data, exp_data); end
    if (busy !== 1'b0) begin errors++; $display("FAIL %s_busy_after: got %b want 0", name, busy); end
  endtask

  task automatic test_checksum();
    int n0, len;
    bit exp_e;
    set_timing(40'h28_001A_0043, 27, 70);
    n0 = done_cnt;
    run_txn(len);
    exp_e = model_error(1'b1);
    if (!exp_e) exp_data = model_frame();
    checks += 3;
    if (done_cnt - n0 != 1) begin errors++; $display("FAIL chk_done_count: got %0d want 1", done_cnt - n0); end
    if (done_err !== exp_e) begin errors++; $display("FAIL chk_error: got %b want %b", done_err, exp_e); end
    if (done_data !== exp_data) begin errors++; $display("FAIL chk_data: got %h want %h", done_data, exp_data); end
  endtask

  task automatic test_no_response();
    int     len;
    bit     seen;
    time    t0, td;
    longint dt;
    seen = 1'b0;
    td   = 0;
    pulse_start();
    wait_release(len);
    t0 = $time;
    for (int k = 0; k < 300; k++) begin
      @(negedge clk);
      if (done) begin
        td   = $time;
        seen = 1'b1;
        break;
      end
    end
    dt = longint'((td - t0) / 10);
    checks += 4;
    if (!seen) begin errors++; $display("FAIL noresp_done: got none want pulse"); end
    if (dt != 201) begin errors++; $display("FAIL noresp_latency: got %0d want 201", dt); end
    if (err !== 1'b1) begin errors++; $display("FAIL noresp_error: got %b want 1", err); end
    @(negedge clk);
    if (busy !== 1'b0) begin errors++; $display("FAIL noresp_busy: got %b want 0", busy); end
    repeat (5) @(negedge clk);
    checks++;
    if (err !== 1'b1) begin errors++; $display("FAIL noresp_error_held: got %b want 1", err); end
  endtask

  task automatic test_stuck_bit();
    int     n0, len;
    bit     exp_e;
    longint dt;
    set_timing(40'h28_001A_0042, 27, 70);
    bit_hi[17] = 300;
    n0 = done_cnt;
    run_txn(len);
    exp_e = model_error(1'b1);
    if (!exp_e) exp_data = model_frame();
    dt = longint'((done_time - rise_time[17]) / 10);
    checks += 4;
    if (done_cnt - n0 != 1) begin errors++; $display("FAIL stuck_done_count: got %0d want 1", done_cnt - n0); end
    if (done_err !== exp_e) begin errors++; $display("FAIL stuck_error: got %b want %b", done_err, exp_e); end
    if (done_data !== exp_data) begin errors++; $display("FAIL stuck_data: got %h want %h", done_data, exp_data); end
    if (dt < 202 || dt > 206) begin errors++; $display("FAIL stuck_latency: got %0d want 202..206", dt); end
  endtask

  task automatic test_reset_mid();
    int n0, len;
    set_timing(40'h28_001A_0042, 27, 70);
    n0 = done_cnt;
    pulse_start();
    wait_release(len);
    sensor_play(20);
    repeat (10) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    exp_data = '0;
    checks += 3;
    if (drv !== 1'b0) begin errors++; $display("FAIL rstmid_drive: got %b want 0", drv); end
    if (busy !== 1'b0) begin errors++; $display("FAIL rstmid_busy: got %b want 0", busy); end
    if (data !== exp_data) begin errors++; $display("FAIL rstmid_data: got %h want %h", data, exp_data); end
    line = 1'b1;
    repeat (300) @(negedge clk);
    checks++;
    if (done_cnt != n0) begin errors++; $display("FAIL rstmid_no_done: got %0d want 0", done_cnt - n0); end
    test_nominal("rstmid_fresh");
  endtask

  task automatic test_threshold_busy();
    int          n0, len;
    bit          exp_e;
    logic [39:0] f;
    f = make_frame(1'b1);
    set_timing(f, ThreshUs, ThreshUs + 1);
    resp_lo    = TimeoutUs;
    bit_lo[10] = TimeoutUs;
    n0 = done_cnt;
    drv_glitch = 0;
    pulse_start();
    wait_release(len);
    start = 1'b1;
    sensor_play(40);
    finish_txn();
    exp_e = model_error(1'b1);
    if (!exp_e) exp_data = model_frame();
    checks += 5;
    if (drv_glitch != 0) begin errors++; $display("FAIL busy_drive_glitch: got %0d want 0", drv_glitch); end
    if (done_cnt - n0 != 1) begin errors++; $display("FAIL thresh_done_count: got %0d want 1", done_cnt - n0); end
    if (done_err !== exp_e) begin errors++; $display("FAIL thresh_error: got %b want %b", done_err, exp_e); end
    if (done_data !== exp_data) begin errors++; $display("FAIL thresh_data: got %h want %h", done_data, exp_data); end
    if (busy !== 1'b0 || drv !== 1'b0) begin
      errors++;
      $display("FAIL start_at_done_restart: got busy=%b drive=%b want 0/0", busy, drv);
    end
  endtask

  task automatic test_timeout_boundary();
    int n0, len;
    bit exp_e;
    set_random_timing(make_frame(1'b1));
    bit_lo[3] = TimeoutUs + 1;
    n0 = done_cnt;
    run_txn(len);
    exp_e = model_error(1'b1);
    if (!exp_e) exp_data = model_frame();
    checks += 3;
    if (done_cnt - n0 != 1) begin errors++; $display("FAIL tmo201_done_count: got %0d want 1", done_cnt - n0); end
    if (done_err !== exp_e) begin errors++; $display("FAIL tmo201_error: got %b want %b", done_err, exp_e); end
    if (done_data !== exp_data) begin errors++; $display("FAIL tmo201_data: got %h want %h", done_data, exp_data); end
  endtask

  task automatic test_random();
    int n0, len;
    bit exp_e;
    for (int t = 0; t < 3; t++) begin
      set_random_timing(make_frame($urandom_range(3, 0) != 0));
      n0 = done_cnt;
      run_txn(len);
      exp_e = model_error(1'b1);
      if (!exp_e) exp_data = model_frame();
      checks += 3;
      if (done_cnt - n0 != 1) begin errors++; $display("FAIL rand%0d_done_count: got %0d want 1", t, done_cnt - n0); end
      if (done_err !== exp_e) begin errors++; $display("FAIL rand%0d_error: got %b want %b", t, done_err, exp_e); end
      if (done_data !== exp_data) begin errors++; $display("FAIL rand%0d_data: got %h want %h", t, done_data, exp_data); end
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_nominal("nominal");
    test_checksum();
    test_no_response();
    test_stuck_bit();
    test_reset_mid();
    test_threshold_busy();
    test_timeout_boundary();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
